// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-requester single-port RAM arbiter (fetch, data, debug)
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_ack,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wmask,
    output logic                  d_ack,
    output logic [31:0]           d_rdata,
    input  logic                  g_req,
    input  logic                  g_we,
    input  logic [31:0]           g_addr,
    input  logic [31:0]           g_wdata,
    output logic                  g_ack,
    output logic [31:0]           g_rdata,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic                  addr_err,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
    typedef enum logic [1:0] {G_IF, G_D, G_G} grant_t;

    state_t state, state_nxt;
    grant_t grant_q, winner;

    logic        last_is_data_q;
    logic        wr_q;
    logic        oor_q;
    logic        any_req;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic [3:0]  sel_ram_we;
    logic        sel_oor;
    logic [31:0] resp_data;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic [31:0] g_rdata_q;
    logic        unused_addr_bits;

    assign any_req = if_req | d_req | g_req;

    // Debug always wins; the CPU ports alternate only when they collide.
    always_comb begin
        winner = G_D;
        if (g_req) begin
            winner = G_G;
        end else if (if_req && d_req) begin
            winner = last_is_data_q ? G_IF : G_D;
        end else if (if_req) begin
            winner = G_IF;
        end
    end

    always_comb begin
        sel_addr   = if_addr;
        sel_wdata  = 32'h0;
        sel_we     = 1'b0;
        sel_ram_we = 4'b0000;
        case (winner)
            G_D: begin
                sel_addr   = d_addr;
                sel_wdata  = d_wdata;
                sel_we     = d_we;
                sel_ram_we = d_we ? d_wmask : 4'b0000;
            end
            G_G: begin
                sel_addr   = g_addr;
                sel_wdata  = g_wdata;
                sel_we     = g_we;
                sel_ram_we = g_we ? 4'b1111 : 4'b0000;
            end
            default: begin
                sel_addr   = if_addr;
                sel_wdata  = 32'h0;
                sel_we     = 1'b0;
                sel_ram_we = 4'b0000;
            end
        endcase
    end

    assign sel_oor          = |sel_addr[31:ADDR_WIDTH+2];
    assign unused_addr_bits = ^sel_addr[1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = any_req ? S_ISSUE : S_IDLE;
            S_ISSUE: state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM strobes are registered at grant so they are live for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            grant_q        <= G_IF;
            last_is_data_q <= 1'b1;
            wr_q           <= 1'b0;
            oor_q          <= 1'b0;
            ram_en         <= 1'b0;
            ram_we         <= 4'b0000;
            ram_addr       <= '0;
            ram_wdata      <= 32'h0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 4'b0000;
            if (state == S_IDLE && any_req) begin
                grant_q   <= winner;
                wr_q      <= sel_we;
                oor_q     <= sel_oor;
                ram_en    <= !sel_oor;
                ram_we    <= sel_oor ? 4'b0000 : sel_ram_we;
                ram_addr  <= sel_addr[ADDR_WIDTH+1:2];
                ram_wdata <= sel_wdata;
                if (winner != G_G) begin
                    last_is_data_q <= (winner == G_D);
                end
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign if_ack    = (state == S_RESP) && (grant_q == G_IF);
    assign d_ack     = (state == S_RESP) && (grant_q == G_D);
    assign g_ack     = (state == S_RESP) && (grant_q == G_G);
    assign addr_err  = (state == S_RESP) && oor_q;
    assign resp_data = (wr_q || oor_q) ? 32'h0 : ram_rdata;

    // RAM data arrives in RESP, so the response word passes straight through
    // that cycle and is held in a shadow register afterwards.
    assign if_rdata = if_ack ? resp_data : if_rdata_q;
    assign d_rdata  = d_ack  ? resp_data : d_rdata_q;
    assign g_rdata  = g_ack  ? resp_data : g_rdata_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
            g_rdata_q  <= 32'h0;
        end else begin
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
            g_rdata_q  <= g_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          if_req, if_ack;
    logic [31:0]   if_addr, if_rdata;
    logic          d_req, d_we, d_ack;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic [3:0]    d_wmask;
    logic          g_req, g_we, g_ack;
    logic [31:0]   g_addr, g_wdata, g_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic          addr_err, busy;

    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;
    logic [31:0]   mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_ack(g_ack), .g_rdata(g_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .addr_err(addr_err), .busy(busy)
    );

    // Synchronous RAM: read-before-write, data valid the cycle after ram_en.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] v);
        pre_en = 1'b1; pre_addr = a; pre_data = v;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
        g_req = 0; g_we = 0; g_addr = 0; g_wdata = 0;
        pre_en = 0; pre_addr = 0; pre_data = 0; ram_rdata = 0;
        tick(); tick();
        total++; if ({if_ack, d_ack, g_ack} !== 3'b000) begin bad++; $display("FAIL reset_acks got=%b want=000", {if_ack, d_ack, g_ack}); end
        total++; if ({ram_en, ram_we, addr_err, busy} !== 7'b0) begin bad++; $display("FAIL reset_ctl got=%b want=0000000", {ram_en, ram_we, addr_err, busy}); end
        total++; if ({if_rdata, d_rdata, g_rdata} !== 96'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", {if_rdata, d_rdata, g_rdata}); end
        total++; if ({ram_addr, ram_wdata} !== {AW'(0), 32'h0}) begin bad++; $display("FAIL reset_ram_bus got=%h want=0", {ram_addr, ram_wdata}); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_fetch;
        preload(8'd2, 32'h00100093);
        if_req = 1; if_addr = 32'h08;
        tick();
        total++; if ({ram_en, ram_we} !== 5'b10000) begin bad++; $display("FAIL fetch_issue en/we got=%b want=10000", {ram_en, ram_we}); end
        total++; if (ram_addr !== 8'd2) begin bad++; $display("FAIL fetch_addr got=%0d want=2", ram_addr); end
        total++; if ({busy, if_ack} !== 2'b10) begin bad++; $display("FAIL fetch_issue busy/ack got=%b want=10", {busy, if_ack}); end
        tick();
        total++; if (if_ack !== 1'b1) begin bad++; $display("FAIL fetch_ack got=%b want=1", if_ack); end
        total++; if (if_rdata !== 32'h00100093) begin bad++; $display("FAIL fetch_rdata got=%h want=00100093", if_rdata); end
        if_req = 0;
        tick();
        total++; if ({if_ack, busy} !== 2'b00) begin bad++; $display("FAIL fetch_after ack/busy got=%b want=00", {if_ack, busy}); end
        total++; if (if_rdata !== 32'h00100093) begin bad++; $display("FAIL fetch_hold got=%h want=00100093", if_rdata); end
    endtask

    task automatic test_byte_write;
        preload(8'd4, 32'h11223344);
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hAABBCCDD; d_wmask = 4'b0011;
        tick();
        total++; if ({ram_en, ram_we} !== 5'b10011) begin bad++; $display("FAIL bw_issue en/we got=%b want=10011", {ram_en, ram_we}); end
        total++; if (ram_wdata !== 32'hAABBCCDD) begin bad++; $display("FAIL bw_wdata got=%h want=aabbccdd", ram_wdata); end
        tick();
        total++; if ({d_ack, d_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL bw_ack ack/rdata got=%b/%h want=1/0", d_ack, d_rdata); end
        d_req = 0;
        tick();
        total++; if (mem[4] !== 32'h1122CCDD) begin bad++; $display("FAIL bw_mem got=%h want=1122ccdd", mem[4]); end
        d_req = 1; d_we = 0;
        tick(); tick();
        total++; if ({d_ack, d_rdata} !== {1'b1, 32'h1122CCDD}) begin bad++; $display("FAIL bw_read ack/rdata got=%b/%h want=1/1122ccdd", d_ack, d_rdata); end
        d_req = 0;
        tick();
    endtask

    task automatic test_zero_mask;
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hFFFFFFFF; d_wmask = 4'b0000;
        tick();
        total++; if ({ram_en, ram_we} !== 5'b10000) begin bad++; $display("FAIL zm_issue en/we got=%b want=10000", {ram_en, ram_we}); end
        tick();
        total++; if ({d_ack, d_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL zm_ack ack/rdata got=%b/%h want=1/0", d_ack, d_rdata); end
        d_req = 0;
        tick();
        total++; if (mem[4] !== 32'h1122CCDD) begin bad++; $display("FAIL zm_mem got=%h want=1122ccdd", mem[4]); end
    endtask

    task automatic test_round_robin;
        logic exp_if, exp_d;
        resetn = 0;
        if_req = 1; if_addr = 32'h08;
        d_req = 1; d_we = 0; d_addr = 32'h10;
        tick();
        resetn = 1;
        for (int c = 0; c < 12; c++) begin
            exp_if = (c == 2) || (c == 8);
            exp_d  = (c == 5) || (c == 11);
            total++; if ({if_ack, d_ack} !== {exp_if, exp_d}) begin bad++; $display("FAIL rr_c%0d if/d got=%b%b want=%b%b", c, if_ack, d_ack, exp_if, exp_d); end
            if (c == 5) begin
                total++; if (d_rdata !== 32'h1122CCDD) begin bad++; $display("FAIL rr_d_rdata got=%h want=1122ccdd", d_rdata); end
            end
            tick();
        end
        if_req = 0; d_req = 0;
        tick();
    endtask

    task automatic test_debug_priority;
        g_req = 1; g_we = 1; g_addr = 32'h0; g_wdata = 32'hDEADBEEF;
        if_req = 1; if_addr = 32'h0;
        tick();
        total++; if ({ram_en, ram_we} !== 5'b11111) begin bad++; $display("FAIL dbg_issue en/we got=%b want=11111", {ram_en, ram_we}); end
        tick();
        total++; if ({g_ack, if_ack, g_rdata} !== {2'b10, 32'h0}) begin bad++; $display("FAIL dbg_ack g/if/rdata got=%b%b/%h want=10/0", g_ack, if_ack, g_rdata); end
        g_req = 0;
        tick(); tick();
        total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL dbg_if_early got=%b want=0", if_ack); end
        tick();
        total++; if ({if_ack, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL dbg_if_ack ack/rdata got=%b/%h want=1/deadbeef", if_ack, if_rdata); end
        if_req = 0;
        tick();
    endtask

    task automatic test_out_of_range;
        d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h12345678; d_wmask = 4'b1111;
        tick();
        total++; if ({ram_en, ram_we} !== 5'b00000) begin bad++; $display("FAIL oor_issue en/we got=%b want=00000", {ram_en, ram_we}); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL oor_busy got=%b want=1", busy); end
        tick();
        total++; if ({d_ack, addr_err, d_rdata} !== {2'b11, 32'h0}) begin bad++; $display("FAIL oor_ack ack/err/rdata got=%b%b/%h want=11/0", d_ack, addr_err, d_rdata); end
        d_req = 0;
        tick();
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got=%b want=0", addr_err); end
        total++; if (mem[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL oor_mem got=%h want=deadbeef", mem[0]); end
    endtask

    task automatic test_reset_mid;
        d_req = 1; d_we = 0; d_addr = 32'h10;
        tick();
        total++; if ({busy, ram_en} !== 2'b11) begin bad++; $display("FAIL mid_issue busy/en got=%b want=11", {busy, ram_en}); end
        resetn = 0;
        if_req = 1; if_addr = 32'h08;
        tick();
        total++; if ({busy, d_ack, ram_en} !== 3'b000) begin bad++; $display("FAIL mid_reset busy/ack/en got=%b want=000", {busy, d_ack, ram_en}); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL mid_reset_rdata got=%h want=0", if_rdata); end
        resetn = 1;
        for (int c = 0; c < 3; c++) begin
            total++; if ({if_ack, d_ack} !== {(c == 2), 1'b0}) begin bad++; $display("FAIL mid_c%0d if/d got=%b%b want=%b0", c, if_ack, d_ack, (c == 2)); end
            tick();
        end
        if_req = 0; d_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_byte_write();
        test_zero_mask();
        test_round_robin();
        test_debug_priority();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
